// File: rtl/sseg_mux_driver.sv
// rtl/sseg_mux_driver.sv - two-digit multiplexed 7-segment driver with frame-synchronous update
//
// Shows an 8-bit value as two hex digits on one shared segment bus. The
// frame cycles DIG0 -> BLANK0 -> DIG1 -> BLANK1. Each digit period is
// followed by an all-off gap. A new value is captured into "pending" on
// load_i. It moves to "shown" only on the edge leaving BLANK1, so a frame
// never mixes old and new digits.
//
// Optional build macro: SSEG_LEADING_ZERO_BLANK_EN
//   When defined, a zero high nibble leaves the DIG1 segments dark.
//   dig_en_o and dp_o are not affected.
//
// Ports
//   clock_i        system clock, all state on posedge
//   reset_n_i      asynchronous active-low reset
//   value_i[7:0]   accumulator value to display
//   load_i         capture value_i into the pending register
//   seg_o[6:0]     segments {g,f,e,d,c,b,a}; inverted when SEG_ACTIVE_LOW=1
//   dp_o           decimal point: pending value not yet shown (DIG1 only)
//   dig_en_o[1:0]  one-hot digit enable, [0]=low nibble, [1]=high nibble
//   frame_start_o  pulse in the first DIG0 cycle of each frame
module sseg_mux_driver #(
   parameter int unsigned DIG_CYCLES     = 1000,
   parameter int unsigned BLANK_CYCLES   = 16,
   parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
   input  logic       clock_i,
   input  logic       reset_n_i,
   input  logic [7:0] value_i,
   input  logic       load_i,
   output logic [6:0] seg_o,
   output logic       dp_o,
   output logic [1:0] dig_en_o,
   output logic       frame_start_o
);

   localparam int unsigned MAX_CYCLES = (DIG_CYCLES > BLANK_CYCLES) ? DIG_CYCLES : BLANK_CYCLES;
   localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
   localparam logic [CNT_W-1:0] DIG_LAST   = CNT_W'(DIG_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_DIG0   = 2'd0,
      ST_BLANK0 = 2'd1,
      ST_DIG1   = 2'd2,
      ST_BLANK1 = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       pending_q, pending_d;
   logic [7:0]       shown_q, shown_d;
   logic             dirty_q, dirty_d;
   logic             state_last;
   logic             frame_edge;
   logic [6:0]       seg_raw;
   logic             dp_raw;

   function automatic logic [6:0] hex7(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   // State register. Reset parks in BLANK1 so the first frame starts
   // with a full blank gap.
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= ST_BLANK1;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + CNT_W'(1);
      state_last = ((state_q == ST_DIG0) || (state_q == ST_DIG1)) ? (cnt_q == DIG_LAST)
                                                                   : (cnt_q == BLANK_LAST);
      if (state_last) begin
         cnt_d = '0;
         case (state_q)
            ST_DIG0:   state_d = ST_BLANK0;
            ST_BLANK0: state_d = ST_DIG1;
            ST_DIG1:   state_d = ST_BLANK1;
            default:   state_d = ST_DIG0;
         endcase
      end
   end

   assign frame_edge = (state_q == ST_BLANK1) && state_last;

   // Data path. At the frame edge, shown takes the pre-edge pending value.
   // A load on that same edge refills pending and keeps dirty set.
   always_comb begin
      pending_d = pending_q;
      shown_d   = shown_q;
      dirty_d   = dirty_q;
      if (frame_edge) begin
         shown_d = pending_q;
         dirty_d = load_i;
      end else if (load_i) begin
         dirty_d = 1'b1;
      end
      if (load_i) begin
         pending_d = value_i;
      end
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         pending_q <= '0;
         shown_q   <= '0;
         dirty_q   <= 1'b0;
      end else begin
         pending_q <= pending_d;
         shown_q   <= shown_d;
         dirty_q   <= dirty_d;
      end
   end

   // Output decode. Only registered state feeds it, so outputs change
   // only at state edges and go dark as soon as reset is asserted.
   always_comb begin
      seg_raw       = 7'h00;
      dp_raw        = 1'b0;
      dig_en_o      = 2'b00;
      frame_start_o = 1'b0;
      case (state_q)
         ST_DIG0: begin
            dig_en_o      = 2'b01;
            seg_raw       = hex7(shown_q[3:0]);
            frame_start_o = (cnt_q == '0);
         end
         ST_DIG1: begin
            dig_en_o = 2'b10;
            dp_raw   = dirty_q;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
            seg_raw  = (shown_q[7:4] == 4'h0) ? 7'h00 : hex7(shown_q[7:4]);
`else
            seg_raw  = hex7(shown_q[7:4]);
`endif
         end
         default: begin
         end
      endcase
   end

   assign seg_o = seg_raw ^ {7{SEG_ACTIVE_LOW}};
   assign dp_o  = dp_raw ^ SEG_ACTIVE_LOW;

endmodule

// File: tb/tb_sseg_mux_driver.sv
// tb/tb_sseg_mux_driver.sv - frame-table checks for sseg_mux_driver
module tb_sseg_mux_driver;

   localparam int unsigned DIG = 4;
   localparam int unsigned BLK = 2;
`ifdef SSEG_LEADING_ZERO_BLANK_EN
   localparam logic [6:0] Z1 = 7'h00;
`else
   localparam logic [6:0] Z1 = 7'h3F;
`endif

   typedef struct {
      int         pa;   // phase of first load, -1 = none
      logic [7:0] va;
      int         pb;   // phase of second load, -1 = none
      logic [7:0] vb;
      logic [6:0] s0;   // expected DIG0 segments
      logic [6:0] s1;   // expected DIG1 segments
      logic       dp1;  // expected dp during DIG1
   } frame_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       load = 1'b0;
   logic [7:0] value = 8'h00;

   logic [6:0] seg_a, seg_b;
   logic       dp_a, dp_b, fs_a, fs_b;
   logic [1:0] en_a, en_b;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   sseg_mux_driver #(.DIG_CYCLES(DIG), .BLANK_CYCLES(BLK), .SEG_ACTIVE_LOW(1'b0)) dut_hi (
      .clock_i(clk), .reset_n_i(reset_n), .value_i(value), .load_i(load),
      .seg_o(seg_a), .dp_o(dp_a), .dig_en_o(en_a), .frame_start_o(fs_a)
   );

   sseg_mux_driver #(.DIG_CYCLES(DIG), .BLANK_CYCLES(BLK), .SEG_ACTIVE_LOW(1'b1)) dut_lo (
      .clock_i(clk), .reset_n_i(reset_n), .value_i(value), .load_i(load),
      .seg_o(seg_b), .dp_o(dp_b), .dig_en_o(en_b), .frame_start_o(fs_b)
   );

   task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got {seg,dp,en,fs}=%h required %h", nm, act, exp);
   endtask

   task automatic check_outputs(input string nm, input logic [6:0] s, input logic dp,
                                input logic [1:0] en, input logic fs);
      chk({nm, " act-high"}, {seg_a, dp_a, en_a, fs_a}, {s, dp, en, fs});
      chk({nm, " act-low"},  {seg_b, dp_b, en_b, fs_b}, {~s, ~dp, en, fs});
   endtask

   // One frame = 12 cycles starting at the first BLANK1 cycle.
   // Phases 0-1 BLANK1, 2-5 DIG0, 6-7 BLANK0, 8-11 DIG1.
   task automatic run_frame(input frame_t f, input string tag);
      logic [6:0] s;
      logic       dp;
      logic [1:0] en;
      logic       fs;
      for (int p = 0; p < 12; p++) begin
         s = 7'h00; dp = 1'b0; en = 2'b00; fs = 1'b0;
         if (p >= 2 && p <= 5) begin
            en = 2'b01; s = f.s0; fs = (p == 2);
         end else if (p >= 8) begin
            en = 2'b10; s = f.s1; dp = f.dp1;
         end
         check_outputs($sformatf("%s p%0d", tag, p), s, dp, en, fs);
         load = 1'b0;
         if (p == f.pa) begin
            load = 1'b1; value = f.va;
         end else if (p == f.pb) begin
            load = 1'b1; value = f.vb;
         end
         @(posedge clk); #1;
         load = 1'b0;
      end
   endtask

   frame_t frames [9];
   frame_t idle_frame;

   initial begin
      frames[0] = '{-1, 8'h00, -1, 8'h00, 7'h3F, Z1,    1'b0}; // reset value, idle
      frames[1] = '{ 3, 8'hA5, -1, 8'h00, 7'h3F, Z1,    1'b1}; // load in DIG0
      frames[2] = '{ 4, 8'h12,  5, 8'h34, 7'h6D, 7'h77, 1'b1}; // shows A5; back-to-back loads
      frames[3] = '{ 6, 8'hA5, -1, 8'h00, 7'h66, 7'h4F, 1'b1}; // shows 34; reload A5
      frames[4] = '{ 1, 8'h5A, -1, 8'h00, 7'h6D, 7'h77, 1'b1}; // load on boundary edge
      frames[5] = '{ 2, 8'h07, -1, 8'h00, 7'h77, 7'h6D, 1'b1}; // shows 5A
      frames[6] = '{-1, 8'h00, -1, 8'h00, 7'h07, Z1,    1'b0}; // shows 07
      frames[7] = '{ 3, 8'hA5, -1, 8'h00, 7'h07, Z1,    1'b1};
      frames[8] = '{-1, 8'h00, -1, 8'h00, 7'h6D, 7'h77, 1'b0}; // shows A5
      idle_frame = '{-1, 8'h00, -1, 8'h00, 7'h3F, Z1, 1'b0};

      #1 reset_n = 1'b0;
      #1 check_outputs("reset async", 7'h00, 1'b0, 2'b00, 1'b0);
      repeat (3) @(posedge clk);
      #1 check_outputs("reset held", 7'h00, 1'b0, 2'b00, 1'b0);
      reset_n = 1'b1;

      for (int i = 0; i < 9; i++) run_frame(frames[i], $sformatf("frame%0d", i));

      // Mid-frame reset while DIG1 shows A5.
      repeat (8) begin
         @(posedge clk); #1;
      end
      check_outputs("pre-reset DIG1", 7'h77, 1'b0, 2'b10, 1'b0);
      reset_n = 1'b0;
      #1 check_outputs("mid-frame reset", 7'h00, 1'b0, 2'b00, 1'b0);
      #1 reset_n = 1'b1;
      run_frame(idle_frame, "post-reset0");
      run_frame(idle_frame, "post-reset1");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
